cpu_nios_ocimem_arbiter: RTL and testbench
==========================================

# cpu_nios_ocimem_arbiter

Sysclk-domain controller that shares the single-port on-chip debug monitor RAM between two requesters: the JTAG command path and the CPU-side Avalon debug slave. It sits after the JTAG debug module's sysclk synchronizer and in front of the monitor RAM. It decodes the `take_action_ocimem_*` strobes and `jdo` payload into addressed read/write operations. It round-robin arbitrates these against CPU slave accesses, sequences the 1-cycle-latency RAM, and returns JTAG read data in `MonDReg`.

## Interface
- `ADDR_W`, 8, monitor RAM word-address width
- `DATA_W`, 32, data width; only 32 is supported
- `clk`  in  1  sole clock
- `reset`  in  1  synchronous, active-high reset
- `take_action_ocimem_a`  in  1  JTAG address-load strobe (1 cycle)
- `take_action_ocimem_b`  in  1  JTAG write strobe (1 cycle)
- `jdo`  in  38  JTAG payload: `[17+ADDR_W-1:17]` address, `[35]` read request, `[34:3]` write data
- `av_address`  in  ADDR_W  CPU slave word address
- `av_read`, `av_write`  in  1  CPU slave read/write requests; never both high
- `av_writedata`  in  32  CPU write data
- `av_readdata`  out  32  CPU read data; valid when `av_read & ~av_waitrequest`
- `av_waitrequest`  out  1  CPU stall
- `mem_addr`  out  ADDR_W  RAM address
- `mem_we`  out  1  RAM write enable
- `mem_wdata`  out  32  RAM write data
- `mem_rdata`  in  32  RAM read data, valid the cycle after address
- `MonDReg`  out  32  last JTAG read or write data
- `monitor_ready`  out  1  no JTAG operation pending or in service
- `monitor_error`  out  1  sticky JTAG overrun flag

## Operation
- JTAG front end: `ocimem_a` loads `jaddr <= jdo` address field and clears `monitor_error`. If `jdo[35]` is set, it also queues a read.
- `ocimem_b` queues a write with `jwdata <= jdo[34:3]`. A single pending slot is used, with `jop` (rd/wr) and `jpend`.
- Overrun: if a strobe arrives while `jpend` or a JTAG service is active, the operation is dropped, `monitor_error` is set, and `jaddr` is unchanged. If `ocimem_a` and `ocimem_b` are high in the same cycle, `ocimem_a` takes effect and `ocimem_b` counts as overrun.
- CPU request is level-sampled: `av_read | av_write` while the FSM is IDLE.
- FSM states are IDLE, GRANT_J, GRANT_C and RDWAIT; `owner` records the granted requester.
- IDLE: if only one requester is pending, it is granted. If both are pending, the requester not equal to `last_grant` wins. `last_grant` is updated on every grant.
- GRANT_x drives `mem_addr` and `mem_we`/`mem_wdata` for exactly one cycle. A write then returns to IDLE; a read goes to RDWAIT.
- RDWAIT, `owner`=CPU: `av_readdata = mem_rdata`, waitrequest low.
- RDWAIT, `owner`=JTAG: `MonDReg <= mem_rdata`.
- A JTAG write also loads `MonDReg <= jwdata`. After each completed JTAG op, `jpend` clears and `jaddr` post-increments mod 2^ADDR_W (see Configuration).
- `av_waitrequest = (av_read|av_write) & ~cpu_done`, where `cpu_done` is (GRANT_C & write) or (RDWAIT & `owner`=CPU).
- `monitor_ready = ~jpend & ~(owner==JTAG & state!=IDLE)`.
- Idle bus: `mem_we`=0, and `mem_addr` holds its last value.

## Timing
- Reset values:
  - state IDLE, `last_grant`=CPU, so JTAG wins the first tie.
  - `jpend`=0, `jaddr`=0.
  - `MonDReg`=0, `monitor_ready`=1, `monitor_error`=0.
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `av_readdata`=0.
- A reset asserted mid-operation aborts the operation. No RAM write is issued in the reset cycle.
- Strobe at cycle T: `jpend` is set at T+1; grant no earlier than T+1.
- CPU write: with no contention, the request is seen at cycle C (IDLE), granted at C+1 with waitrequest low at C+1. Latency is 2 cycles.
- CPU read: granted at C+1, data and waitrequest low at C+2. Latency is 3 cycles.
- JTAG read: strobe at T; `MonDReg` updates and `monitor_ready` rises at T+4.
- JTAG write: strobe at T; `mem_we` at T+2; `monitor_ready` rises at T+3.
- Back-to-back operations require a return through IDLE for one cycle. Maximum RAM utilisation is 1 op per 2 cycles (writes) or 3 cycles (reads).

## Configuration
- `CPU_NIOS_OCIMEM_AUTOINC_EN` defined: `jaddr` post-increments after every completed JTAG op and wraps from 2^ADDR_W-1 to 0.
- Not defined: `jaddr` changes only on `ocimem_a`; repeated `ocimem_b` strobes rewrite the same word.

## Test plan
- Reset: assert `reset` for 2 cycles mid CPU read -> all outputs at the listed reset values; `av_waitrequest`=1 while `av_read` is still high; no `mem_we` pulse.
- JTAG write then read, autoinc on:
  - stimulus: `ocimem_a` addr=0x10 (read bit 0), then `ocimem_b` data=0xDEADBEEF, then `ocimem_a` addr=0x10 with `jdo[35]`=1.
  - response: RAM[0x10]=0xDEADBEEF; `MonDReg`=0xDEADBEEF at T+4; `jaddr`=0x11.
- Simultaneous requests: CPU read 0x20 and JTAG read pending in the same IDLE cycle after reset -> JTAG granted first, CPU second; repeat -> CPU first.
- Overrun: `ocimem_b` issued 1 cycle after a prior `ocimem_b` -> second write dropped, `monitor_error`=1; next `ocimem_a` clears it.
- Wrap: `ocimem_a` addr=0xFF, two `ocimem_b` writes 0x1, 0x2 -> RAM[0xFF]=0x1, RAM[0x00]=0x2. With the macro undefined -> RAM[0xFF]=0x2.
- CPU latency: isolated `av_write` 0x05=0x1234 -> waitrequest low in the 2nd cycle. `av_read` 0x05 -> `av_readdata`=0x1234 with waitrequest low in the 3rd cycle.

Source files
------------

// File: rtl/cpu_nios_ocimem_arbiter.sv
// Sysclk-side arbiter sharing the debug monitor RAM between the JTAG command path and the CPU slave.
// Define CPU_NIOS_OCIMEM_AUTOINC_EN to post-increment the JTAG address after every completed op.
module cpu_nios_ocimem_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [37:0]       jdo,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [DATA_W-1:0] av_writedata,
  output logic [DATA_W-1:0] av_readdata,
  output logic              av_waitrequest,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [DATA_W-1:0] MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  typedef enum logic [1:0] {IDLE, GRANT_J, GRANT_C, RDWAIT} state_t;
  localparam logic OWN_C = 1'b0;
  localparam logic OWN_J = 1'b1;

`ifdef CPU_NIOS_OCIMEM_AUTOINC_EN
  localparam logic [ADDR_W-1:0] JADDR_STEP = ADDR_W'(1);
`else
  localparam logic [ADDR_W-1:0] JADDR_STEP = '0;
`endif

  state_t            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              cur_rd_q, cur_rd_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [ADDR_W-1:0] jaddr_q, jaddr_d;
  logic [DATA_W-1:0] jwdata_q, jwdata_d;
  logic              jop_rd_q, jop_rd_d;
  logic              jpend_q, jpend_d;
  logic [DATA_W-1:0] mon_dreg_q, mon_dreg_d;
  logic              mon_err_q, mon_err_d;

  logic cpu_req, j_busy, cpu_done;
  logic unused_jdo;

  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};
  assign cpu_req    = av_read | av_write;
  assign j_busy     = jpend_q | (owner_q == OWN_J && state_q != IDLE);
  assign cpu_done   = (state_q == GRANT_C && av_write) || (state_q == RDWAIT && owner_q == OWN_C);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    cur_rd_d     = cur_rd_q;
    mem_addr_d   = mem_addr_q;
    mem_we_d     = 1'b0;
    mem_wdata_d  = mem_wdata_q;
    jaddr_d      = jaddr_q;
    jwdata_d     = jwdata_q;
    jop_rd_d     = jop_rd_q;
    jpend_d      = jpend_q;
    mon_dreg_d   = mon_dreg_q;
    mon_err_d    = mon_err_q;

    // Single pending slot: anything arriving while it is occupied is an overrun.
    if (take_action_ocimem_a) begin
      if (j_busy) begin
        mon_err_d = 1'b1;
      end else begin
        jaddr_d   = jdo[17 +: ADDR_W];
        mon_err_d = 1'b0;
        if (jdo[35]) begin
          jpend_d  = 1'b1;
          jop_rd_d = 1'b1;
        end
      end
    end
    if (take_action_ocimem_b) begin
      if (take_action_ocimem_a || j_busy) begin
        mon_err_d = 1'b1;
      end else begin
        jpend_d  = 1'b1;
        jop_rd_d = 1'b0;
        jwdata_d = jdo[3 +: DATA_W];
      end
    end

    case (state_q)
      IDLE: begin
        if (jpend_q && (!cpu_req || last_grant_q == OWN_C)) begin
          state_d      = GRANT_J;
          owner_d      = OWN_J;
          last_grant_d = OWN_J;
          cur_rd_d     = jop_rd_q;
          mem_addr_d   = jaddr_q;
          mem_we_d     = ~jop_rd_q;
          if (!jop_rd_q) mem_wdata_d = jwdata_q;
        end else if (cpu_req) begin
          state_d      = GRANT_C;
          owner_d      = OWN_C;
          last_grant_d = OWN_C;
          cur_rd_d     = ~av_write;
          mem_addr_d   = av_address;
          mem_we_d     = av_write;
          if (av_write) mem_wdata_d = av_writedata;
        end
      end
      GRANT_J: begin
        if (cur_rd_q) begin
          state_d = RDWAIT;
        end else begin
          state_d    = IDLE;
          jpend_d    = 1'b0;
          mon_dreg_d = jwdata_q;
          jaddr_d    = jaddr_q + JADDR_STEP;
        end
      end
      GRANT_C: state_d = cur_rd_q ? RDWAIT : IDLE;
      RDWAIT: begin
        state_d = IDLE;
        if (owner_q == OWN_J) begin
          jpend_d    = 1'b0;
          mon_dreg_d = mem_rdata;
          jaddr_d    = jaddr_q + JADDR_STEP;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      owner_q      <= OWN_C;
      last_grant_q <= OWN_C;
      cur_rd_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_we_q     <= 1'b0;
      mem_wdata_q  <= '0;
      jaddr_q      <= '0;
      jwdata_q     <= '0;
      jop_rd_q     <= 1'b0;
      jpend_q      <= 1'b0;
      mon_dreg_q   <= '0;
      mon_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      cur_rd_q     <= cur_rd_d;
      mem_addr_q   <= mem_addr_d;
      mem_we_q     <= mem_we_d;
      mem_wdata_q  <= mem_wdata_d;
      jaddr_q      <= jaddr_d;
      jwdata_q     <= jwdata_d;
      jop_rd_q     <= jop_rd_d;
      jpend_q      <= jpend_d;
      mon_dreg_q   <= mon_dreg_d;
      mon_err_q    <= mon_err_d;
    end
  end

  // Gate the write strobe so a reset landing on a grant cycle never reaches the RAM.
  assign mem_we         = mem_we_q & ~reset;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign av_readdata    = (state_q == RDWAIT && owner_q == OWN_C) ? mem_rdata : '0;
  assign av_waitrequest = cpu_req & ~cpu_done;
  assign MonDReg        = mon_dreg_q;
  assign monitor_error  = mon_err_q;
  assign monitor_ready  = ~jpend_q & ~(owner_q == OWN_J && state_q != IDLE);

endmodule

// File: tb/tb_cpu_nios_ocimem_arbiter.sv
// Directed bench for cpu_nios_ocimem_arbiter with a 1-cycle-latency RAM model.
module tb_cpu_nios_ocimem_arbiter;
  logic        clk = 1'b0, reset = 1'b1, ta = 1'b0, tb = 1'b0;
  logic [37:0] jdo = '0;
  logic [7:0]  av_address = '0;
  logic        av_read = 1'b0, av_write = 1'b0;
  logic [31:0] av_writedata = '0;
  logic [31:0] av_readdata, mem_wdata, MonDReg;
  logic        av_waitrequest, mem_we, monitor_ready, monitor_error;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata = '0;
  logic [31:0] ram [256];
  bit          written [256];
  int          checks = 0, failures = 0;

`ifdef CPU_NIOS_OCIMEM_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  always #5 clk = ~clk;

  cpu_nios_ocimem_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .take_action_ocimem_a(ta), .take_action_ocimem_b(tb), .jdo(jdo),
    .av_address(av_address), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
    .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error)
  );

  // Unwritten words read back as a recognisable address-tagged pattern.
  function automatic logic [31:0] rd_ram(input logic [7:0] a);
    return written[a] ? ram[a] : {24'hA50000, a};
  endfunction

  always @(posedge clk) begin
    mem_rdata <= rd_ram(mem_addr);
    if (mem_we) begin
      ram[mem_addr]     <= mem_wdata;
      written[mem_addr] <= 1'b1;
    end
  end

  function automatic logic [37:0] jdo_a(input logic [7:0] a, input logic rd);
    logic [37:0] v = '0;
    v[24:17] = a;
    v[35]    = rd;
    return v;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] d);
    logic [37:0] v = '0;
    v[34:3] = d;
    return v;
  endfunction

  task automatic nc();
    @(negedge clk);
    ta = 1'b0;
    tb = 1'b0;
  endtask

  task automatic test_reset_state();
    nc(); #1;
    nc(); #1;
    checks++; if (MonDReg !== 32'h0) begin failures++; $display("FAIL rst_mondreg: got %h exp 0", MonDReg); end
    checks++; if (monitor_ready !== 1'b1 || monitor_error !== 1'b0) begin failures++; $display("FAIL rst_flags: got rdy=%b err=%b exp rdy=1 err=0", monitor_ready, monitor_error); end
    checks++; if (mem_we !== 1'b0 || mem_addr !== 8'h0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL rst_mem: got we=%b a=%h d=%h exp 0/0/0", mem_we, mem_addr, mem_wdata); end
    checks++; if (av_readdata !== 32'h0 || av_waitrequest !== 1'b0) begin failures++; $display("FAIL rst_av: got rd=%h wr=%b exp 0/0", av_readdata, av_waitrequest); end
    nc(); reset = 1'b0; #1;
  endtask

  task automatic test_jtag_wr_rd();
    nc(); ta = 1'b1; jdo = jdo_a(8'h10, 1'b0); #1;
    nc(); tb = 1'b1; jdo = jdo_b(32'hDEADBEEF); #1;
    checks++; if (monitor_ready !== 1'b1) begin failures++; $display("FAIL wr_ready_pre: got %b exp 1", monitor_ready); end
    nc(); #1;
    checks++; if (monitor_ready !== 1'b0) begin failures++; $display("FAIL wr_pending: got %b exp 0", monitor_ready); end
    nc(); #1;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 8'h10 || mem_wdata !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_bus: got we=%b a=%h d=%h exp 1/10/deadbeef", mem_we, mem_addr, mem_wdata); end
    nc(); #1;
    checks++; if (monitor_ready !== 1'b1 || MonDReg !== 32'hDEADBEEF) begin failures++; $display("FAIL wr_done: got rdy=%b mon=%h exp 1/deadbeef", monitor_ready, MonDReg); end
    checks++; if (rd_ram(8'h10) !== 32'hDEADBEEF || mem_we !== 1'b0) begin failures++; $display("FAIL wr_ram: got %h we=%b exp deadbeef we=0", rd_ram(8'h10), mem_we); end
    nc(); ta = 1'b1; jdo = jdo_a(8'h10, 1'b1); #1;
    nc(); #1;
    nc(); #1;
    checks++; if (mem_addr !== 8'h10 || mem_we !== 1'b0) begin failures++; $display("FAIL rd_bus: got a=%h we=%b exp 10/0", mem_addr, mem_we); end
    nc(); #1;
    checks++; if (monitor_ready !== 1'b0) begin failures++; $display("FAIL rd_busy_t3: got %b exp 0", monitor_ready); end
    nc(); #1;
    checks++; if (monitor_ready !== 1'b1 || MonDReg !== 32'hDEADBEEF) begin failures++; $display("FAIL rd_done_t4: got rdy=%b mon=%h exp 1/deadbeef", monitor_ready, MonDReg); end
    nc(); tb = 1'b1; jdo = jdo_b(32'h0BADF00D); #1;
    nc(); #1;
    nc(); #1;
    checks++; if (mem_we !== 1'b1 || mem_addr !== (AUTOINC ? 8'h11 : 8'h10)) begin failures++; $display("FAIL jaddr_after_rd: got we=%b a=%h exp 1/%h", mem_we, mem_addr, AUTOINC ? 8'h11 : 8'h10); end
    nc(); #1;
  endtask

  task automatic test_overrun();
    nc(); tb = 1'b1; jdo = jdo_b(32'h11111111); #1;
    nc(); tb = 1'b1; jdo = jdo_b(32'h22222222); #1;
    checks++; if (monitor_error !== 1'b0) begin failures++; $display("FAIL ovr_err_pre: got %b exp 0", monitor_error); end
    nc(); #1;
    checks++; if (monitor_error !== 1'b1 || mem_we !== 1'b1 || mem_wdata !== 32'h11111111) begin failures++; $display("FAIL ovr_first: got err=%b we=%b d=%h exp 1/1/11111111", monitor_error, mem_we, mem_wdata); end
    nc(); #1;
    checks++; if (monitor_ready !== 1'b1 || MonDReg !== 32'h11111111 || monitor_error !== 1'b1) begin failures++; $display("FAIL ovr_done: got rdy=%b mon=%h err=%b exp 1/11111111/1", monitor_ready, MonDReg, monitor_error); end
    nc(); #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL ovr_dropped: got we=%b exp 0", mem_we); end
    nc(); ta = 1'b1; jdo = jdo_a(8'h40, 1'b0); #1;
    nc(); #1;
    checks++; if (monitor_error !== 1'b0) begin failures++; $display("FAIL ovr_clear: got %b exp 0", monitor_error); end
    nc(); ta = 1'b1; tb = 1'b1; jdo = jdo_a(8'h41, 1'b0); #1;
    nc(); #1;
    checks++; if (monitor_error !== 1'b1 || monitor_ready !== 1'b1) begin failures++; $display("FAIL ovr_ab_same: got err=%b rdy=%b exp 1/1", monitor_error, monitor_ready); end
    nc(); #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL ovr_ab_nowrite: got we=%b exp 0", mem_we); end
  endtask

  task automatic test_cpu_latency();
    nc(); av_write = 1'b1; av_address = 8'h05; av_writedata = 32'h1234; #1;
    checks++; if (av_waitrequest !== 1'b1) begin failures++; $display("FAIL cw_c0: got wait=%b exp 1", av_waitrequest); end
    nc(); #1;
    checks++; if (av_waitrequest !== 1'b0 || mem_we !== 1'b1 || mem_addr !== 8'h05 || mem_wdata !== 32'h1234) begin failures++; $display("FAIL cw_c1: got wait=%b we=%b a=%h d=%h exp 0/1/05/1234", av_waitrequest, mem_we, mem_addr, mem_wdata); end
    nc(); av_write = 1'b0; av_read = 1'b1; #1;
    checks++; if (av_waitrequest !== 1'b1) begin failures++; $display("FAIL cr_c0: got wait=%b exp 1", av_waitrequest); end
    nc(); #1;
    checks++; if (av_waitrequest !== 1'b1 || mem_we !== 1'b0) begin failures++; $display("FAIL cr_c1: got wait=%b we=%b exp 1/0", av_waitrequest, mem_we); end
    nc(); #1;
    checks++; if (av_waitrequest !== 1'b0 || av_readdata !== 32'h1234) begin failures++; $display("FAIL cr_c2: got wait=%b rd=%h exp 0/1234", av_waitrequest, av_readdata); end
    nc(); av_read = 1'b0; #1;
  endtask

  task automatic test_reset();
    nc(); av_read = 1'b1; av_address = 8'h07; #1;
    nc(); reset = 1'b1; #1;
    nc(); #1;
    checks++; if (av_waitrequest !== 1'b1 || av_readdata !== 32'h0) begin failures++; $display("FAIL mrst_av: got wait=%b rd=%h exp 1/0", av_waitrequest, av_readdata); end
    checks++; if (MonDReg !== 32'h0 || monitor_ready !== 1'b1 || monitor_error !== 1'b0) begin failures++; $display("FAIL mrst_mon: got mon=%h rdy=%b err=%b exp 0/1/0", MonDReg, monitor_ready, monitor_error); end
    checks++; if (mem_we !== 1'b0 || mem_addr !== 8'h0 || mem_wdata !== 32'h0) begin failures++; $display("FAIL mrst_mem: got we=%b a=%h d=%h exp 0/0/0", mem_we, mem_addr, mem_wdata); end
    nc(); reset = 1'b0; av_read = 1'b0; #1;
    nc(); av_write = 1'b1; av_address = 8'h08; av_writedata = 32'h5555; #1;
    nc(); reset = 1'b1; #1;
    checks++; if (mem_we !== 1'b0) begin failures++; $display("FAIL mrst_we_gate: got we=%b exp 0", mem_we); end
    nc(); reset = 1'b0; av_write = 1'b0; #1;
    checks++; if (rd_ram(8'h08) !== 32'hA5000008) begin failures++; $display("FAIL mrst_no_write: got %h exp a5000008", rd_ram(8'h08)); end
  endtask

  task automatic test_simultaneous();
    nc(); ta = 1'b1; jdo = jdo_a(8'h30, 1'b1); #1;
    nc(); av_read = 1'b1; av_address = 8'h20; #1;
    nc(); #1;
    checks++; if (mem_addr !== 8'h30 || av_waitrequest !== 1'b1) begin failures++; $display("FAIL tie1_jfirst: got a=%h wait=%b exp 30/1", mem_addr, av_waitrequest); end
    nc(); #1;
    nc(); #1;
    checks++; if (MonDReg !== 32'hA5000030 || monitor_ready !== 1'b1 || av_waitrequest !== 1'b1) begin failures++; $display("FAIL tie1_jdone: got mon=%h rdy=%b wait=%b exp a5000030/1/1", MonDReg, monitor_ready, av_waitrequest); end
    nc(); #1;
    checks++; if (mem_addr !== 8'h20) begin failures++; $display("FAIL tie1_csecond: got a=%h exp 20", mem_addr); end
    nc(); #1;
    checks++; if (av_waitrequest !== 1'b0 || av_readdata !== 32'hA5000020) begin failures++; $display("FAIL tie1_cdata: got wait=%b rd=%h exp 0/a5000020", av_waitrequest, av_readdata); end
    nc(); av_read = 1'b0; ta = 1'b1; jdo = jdo_a(8'h31, 1'b1); #1;
    nc(); #1;
    nc(); #1;
    nc(); #1;
    nc(); #1;
    checks++; if (MonDReg !== 32'hA5000031 || monitor_ready !== 1'b1) begin failures++; $display("FAIL solo_jrd: got mon=%h rdy=%b exp a5000031/1", MonDReg, monitor_ready); end
    nc(); ta = 1'b1; jdo = jdo_a(8'h32, 1'b1); #1;
    nc(); av_read = 1'b1; av_address = 8'h21; #1;
    nc(); #1;
    checks++; if (mem_addr !== 8'h21) begin failures++; $display("FAIL tie2_cfirst: got a=%h exp 21", mem_addr); end
    nc(); #1;
    checks++; if (av_waitrequest !== 1'b0 || av_readdata !== 32'hA5000021 || monitor_ready !== 1'b0) begin failures++; $display("FAIL tie2_cdata: got wait=%b rd=%h rdy=%b exp 0/a5000021/0", av_waitrequest, av_readdata, monitor_ready); end
    nc(); av_read = 1'b0; #1;
    nc(); #1;
    checks++; if (mem_addr !== 8'h32) begin failures++; $display("FAIL tie2_jsecond: got a=%h exp 32", mem_addr); end
    nc(); #1;
    nc(); #1;
    checks++; if (MonDReg !== 32'hA5000032 || monitor_ready !== 1'b1) begin failures++; $display("FAIL tie2_jdone: got mon=%h rdy=%b exp a5000032/1", MonDReg, monitor_ready); end
  endtask

  task automatic test_wrap();
    nc(); ta = 1'b1; jdo = jdo_a(8'hFF, 1'b0); #1;
    nc(); tb = 1'b1; jdo = jdo_b(32'h1); #1;
    nc(); #1;
    nc(); #1;
    checks++; if (mem_we !== 1'b1 || mem_addr !== 8'hFF) begin failures++; $display("FAIL wrap_w1: got we=%b a=%h exp 1/ff", mem_we, mem_addr); end
    nc(); tb = 1'b1; jdo = jdo_b(32'h2); #1;
    nc(); #1;
    nc(); #1;
    checks++; if (mem_we !== 1'b1 || mem_addr !== (AUTOINC ? 8'h00 : 8'hFF)) begin failures++; $display("FAIL wrap_w2: got we=%b a=%h exp 1/%h", mem_we, mem_addr, AUTOINC ? 8'h00 : 8'hFF); end
    nc(); #1;
    checks++; if (rd_ram(8'hFF) !== (AUTOINC ? 32'h1 : 32'h2)) begin failures++; $display("FAIL wrap_ramff: got %h exp %h", rd_ram(8'hFF), AUTOINC ? 32'h1 : 32'h2); end
    checks++; if (rd_ram(8'h00) !== (AUTOINC ? 32'h2 : 32'hA5000000)) begin failures++; $display("FAIL wrap_ram00: got %h exp %h", rd_ram(8'h00), AUTOINC ? 32'h2 : 32'hA5000000); end
  endtask

  initial begin
    test_reset_state();
    test_jtag_wr_rd();
    test_overrun();
    test_cpu_latency();
    test_reset();
    test_simultaneous();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
